// File: rtl/sp_ram_rf_sine.sv
// Single-port 2^ADDR_W x DATA_W register-file RAM that powers up holding one sine period.
// Define SP_RAM_SINE_RESET_RELOAD_EN to make rst also restore the sine table.
module sp_ram_rf_sine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] qout
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [DEPTH-1:0][DATA_W-1:0] table_t;

    // Offset-binary sine. The int'() cast of a real rounds half away from zero.
    function automatic table_t sine_table();
        table_t t;
        int     off;
        int     amp;
        real    two_pi;
        off    = 1 << (DATA_W - 1);
        amp    = off - 1;
        two_pi = 6.283185307179586;
        for (int i = 0; i < DEPTH; i++) begin
            t[i] = DATA_W'(off + int'(real'(amp) * $sin(two_pi * real'(i) / real'(DEPTH))));
        end
        return t;
    endfunction

    table_t sine_rom;
    table_t delta;

    assign sine_rom = sine_table();

    // Each entry is stored as its difference from the sine table, so the all-zero
    // power-up state of the registers reads back as the sine wave itself.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep the read of delta[addr] seeing the pre-edge value.
        if (rst) begin
            qout <= '0;
`ifdef SP_RAM_SINE_RESET_RELOAD_EN
            delta <= '0;
`endif
            // NOTE: without the reload option the storage array is deliberately not reset.
        end else if (we) begin
            delta[addr] <= din ^ sine_rom[addr];
            qout        <= din;
        end else begin
            qout <= sine_rom[addr] ^ delta[addr];
        end
    end

endmodule

// File: tb/tb_sp_ram_rf_sine.sv
// Scoreboard bench for sp_ram_rf_sine: stimulus pushes expected qout values,
// a monitor pops and compares one entry per clock edge.
module tb_sp_ram_rf_sine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = 8'h00;
    logic       we = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] qout;

    typedef struct {
        logic       chk;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] shadow [256];

    sp_ram_rf_sine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .qout (qout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sine_ref(int i);
        real r;
        real q;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
        q = (r >= 0.0) ? $floor(r + 0.5) : -$floor(-r + 0.5);
        return 8'($rtoi(128.0 + q));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: qout=%02h expected %02h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the expected qout after the coming edge is queued.
    task automatic step(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic c, input logic [7:0] exp,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst  = r;
        we   = w;
        addr = a;
        din  = d;
        e.chk  = c;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        if (!r && w) shadow[a] = d;
    endtask

    task automatic rd(input logic [7:0] a, input string name);
        step(1'b0, 1'b0, a, 8'h00, 1'b1, shadow[a], name);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input string name);
        step(1'b0, 1'b1, a, d, 1'b1, d, name);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) check(e.name, qout, e.exp);
        end
    end

    // Hand-computed sine values for addresses 0x00..0x10 that the patch test leaves intact.
    logic [7:0] hand_addr [12] = '{8'h00, 8'h02, 8'h04, 8'h05, 8'h07, 8'h08,
                                   8'h09, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h10};
    logic [7:0] hand_val  [12] = '{8'h80, 8'h86, 8'h8C, 8'h90, 8'h96, 8'h99,
                                   8'h9C, 8'hA2, 8'hA5, 8'hA8, 8'hAB, 8'hB1};
    logic [7:0] wr_addr [5] = '{8'h01, 8'h03, 8'h06, 8'h0A, 8'h0F};
    logic [7:0] wr_data [5] = '{8'h10, 8'h30, 8'h60, 8'hA0, 8'hF0};

    initial begin
        int budget;
        for (int i = 0; i < 256; i++) shadow[i] = sine_ref(i);

        // Reset for two cycles, with power-up contents untouched.
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "reset_0");
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "reset_1");

        // Key table points, hand-computed.
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h80, "sine_00");
        step(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 8'hFF, "sine_40");
        step(1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 8'h80, "sine_80");
        step(1'b0, 1'b0, 8'hC0, 8'h00, 1'b1, 8'h01, "sine_C0");
        step(1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'hDA, "sine_20");
        step(1'b0, 1'b0, 8'h60, 8'h00, 1'b1, 8'hDA, "sine_60");
        step(1'b0, 1'b0, 8'hA0, 8'h00, 1'b1, 8'h26, "sine_A0");
        step(1'b0, 1'b0, 8'hE0, 8'h00, 1'b1, 8'h26, "sine_E0");

        // Back-to-back patches; write-first shows din on qout.
        for (int i = 0; i < 5; i++) wr(wr_addr[i], wr_data[i], $sformatf("patch_wr_%02h", wr_addr[i]));
        for (int i = 0; i <= 16; i++) begin
            logic [7:0] exp;
            exp = 8'hxx;
            for (int k = 0; k < 5; k++) if (wr_addr[k] == 8'(i)) exp = wr_data[k];
            for (int k = 0; k < 12; k++) if (hand_addr[k] == 8'(i)) exp = hand_val[k];
            step(1'b0, 1'b0, 8'(i), 8'h00, 1'b1, exp, $sformatf("patch_rd_%02h", i));
        end

        // Read-during-write, then a later read of the same entry.
        wr(8'h40, 8'h5A, "rdw_40");
        rd(8'h41, "rdw_next");
        rd(8'h40, "rdw_readback");

        // Full sweep with wrap back to address 0.
        for (int i = 0; i < 256; i++) rd(8'(i), $sformatf("sweep_%02h", i));
        rd(8'h00, "sweep_wrap");

        // Top-of-range write and wrap to bottom.
        wr(8'hFF, 8'h3C, "wr_FF");
        rd(8'hFF, "rd_FF");
        rd(8'h00, "rd_FF_wrap");

        // Write during reset is discarded; reload depends on the build option.
        wr(8'h40, 8'h00, "pre_rst_wr_40");
        step(1'b1, 1'b1, 8'h40, 8'h77, 1'b1, 8'h00, "rst_with_we");
`ifdef SP_RAM_SINE_RESET_RELOAD_EN
        for (int i = 0; i < 256; i++) shadow[i] = sine_ref(i);
        step(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 8'hFF, "post_rst_40");
        step(1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h83, "post_rst_01");
`else
        step(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 8'h00, "post_rst_40");
        step(1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h10, "post_rst_01");
`endif

        // Reset in the middle of a sweep.
        for (int i = 8'h20; i < 8'h28; i++) begin
            if (i == 8'h23 || i == 8'h24)
                step(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 8'h00, $sformatf("midrst_%02h", i));
            else
                rd(8'(i), $sformatf("midsweep_%02h", i));
        end

        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
